ram_read_streamer: RTL
======================

// Module: ram_read_streamer
// PURPOSE
//  Downstream consumer of the read port of the dual-clock simulation/buffer RAM.
//  Takes a (base address, length) command and drives the RAM read address.
//  Tracks the RAM's fixed read latency (DELAY+1 cycles).
//  Returns the words as a valid/ready stream with o_last on the final word.
//  A credit-counted skid FIFO absorbs backpressure, so no returning RAM word is ever lost.
// PARAMETERS
//  DATA_R      8   RAM read-word width; equals the RAM's DATA_R
//  DEPTH_R     8   RAM read-address width; equals the RAM's DEPTH_R
//  DELAY       0   extra RAM output register stages; equals the RAM's DELAY
//  FIFO_DEPTH  4   skid FIFO entries, >=1; full throughput requires FIFO_DEPTH >= DELAY+3
// PORTS
//  clk          in   1          single clock; tied to the RAM's r_clk
//  rst          in   1          synchronous, active-high reset
//  i_start      in   1          command strobe; accepted only in IDLE
//  i_base_addr  in   DEPTH_R    first read address
//  i_len        in   DEPTH_R+1  number of words to read; 0 is legal
//  o_busy       out  1          high in every state except IDLE
//  o_done       out  1          one-cycle pulse when a command completes
//  o_raddr      out  DEPTH_R    to RAM i_raddr
//  i_rdata      in   DATA_R     from RAM o_rdata
//  o_valid      out  1          stream data valid
//  o_data       out  DATA_R     stream data
//  o_last       out  1          high with the final word of a command
//  i_ready      in   1          stream consumer ready
// BEHAVIOUR
//  Reset values: o_busy=0, o_done=0, o_valid=0, o_last=0, o_raddr=0, o_data=0.
//  Reset also clears: FSM, counters, in-flight pipe, FIFO.
//  FSM states: IDLE, RUN, DRAIN, DONE.
//   IDLE->RUN when i_start=1 and i_len!=0; base address and length are latched.
//   IDLE->DONE when i_start=1 and i_len==0; o_done pulses, no stream output.
//   RUN->DRAIN in the cycle the last address is issued.
//   DRAIN->DONE on the handshake (o_valid&i_ready&o_last).
//   DONE->IDLE unconditionally; o_done=1 only while in DONE.
//  i_start is ignored when not in IDLE. Commands are never queued.
//  Issue rule (RUN only): a read issues in a cycle when inflight+fifo_count < FIFO_DEPTH.
//   Both counts are registered; a pop frees a credit only from the next cycle.
//   On issue, o_raddr holds the current address.
//   The address register increments modulo 2^DEPTH_R, so reads wrap from 2^DEPTH_R-1 to 0.
//   When not issuing, o_raddr holds its value. The RAM reads it anyway; the data is discarded.
//  Latency tracking: a (DELAY+1)-deep valid shift register carries issue tokens.
//   A read issued in cycle t is pushed into the FIFO from i_rdata sampled at the end of cycle t+DELAY+1.
//   That push is guaranteed by credit and is never dropped.
//   The o_last flag travels with the token of the final address.
//  FIFO: registered outputs. o_valid = FIFO not empty; o_data/o_last come from the head entry.
//   Push and pop in the same cycle are allowed at any occupancy.
//   Order is preserved, with no bubbles when i_ready=1 and FIFO_DEPTH >= DELAY+3.
//  Timing: i_start sampled at edge s; first issue in cycle s+1; first o_valid in cycle s+DELAY+3.
//   With i_ready held high, one word per cycle after that.
//  Stream rule: once o_valid is asserted, o_valid, o_data and o_last hold until i_ready=1.
//  Reset mid-command: returns to IDLE next cycle. No o_done pulse.
//   RAM words still in flight are ignored because the valid pipe was cleared.
//  inflight never exceeds DELAY+1; inflight+fifo_count never exceeds FIFO_DEPTH.
// TESTING
//  1 DELAY=0, base=0x10, len=4, RAM[n]=n, i_ready=1:
//    -> data 0x10..0x13 on consecutive cycles from s+3; o_last on 0x13; o_done one cycle later.
//  2 base=0xFE, len=4 (DEPTH_R=8):
//    -> o_raddr sequence FE,FF,00,01; data in that order; o_last on 01.
//  3 len=0:
//    -> o_done pulses one cycle after start; o_valid never asserts.
//  4 len=16, i_ready toggling 1 cycle on / 3 cycles off, DELAY=2, FIFO_DEPTH=5:
//    -> all 16 words in order, none dropped or duplicated; count stays <= 5.
//  5 i_start pulsed again mid-RUN with other operands:
//    -> ignored; the original stream completes unchanged.
//  6 rst asserted with 3 words in flight:
//    -> next cycle o_valid=0, o_busy=0; no stray words appear afterwards.
//    -> a new len=2 command returns exactly 2 words.

Source files
------------

// File: rtl/ram_read_streamer_if.sv
// Bundles the command, RAM read-port and output-stream signals of ram_read_streamer.
// slave is the streamer side. master is the side that drives commands, returns RAM data and consumes the stream.
interface ram_read_streamer_if #(
  parameter int DATA_R  = 8,
  parameter int DEPTH_R = 8
);
  logic               i_start;
  logic [DEPTH_R-1:0] i_base_addr;
  logic [DEPTH_R:0]   i_len;
  logic               o_busy;
  logic               o_done;
  logic [DEPTH_R-1:0] o_raddr;
  logic [DATA_R-1:0]  i_rdata;
  logic               o_valid;
  logic [DATA_R-1:0]  o_data;
  logic               o_last;
  logic               i_ready;

  modport slave (
    input  i_start, i_base_addr, i_len, i_rdata, i_ready,
    output o_busy, o_done, o_raddr, o_valid, o_data, o_last
  );

  modport master (
    output i_start, i_base_addr, i_len, i_rdata, i_ready,
    input  o_busy, o_done, o_raddr, o_valid, o_data, o_last
  );
endinterface

// File: rtl/ram_read_streamer.sv
// Reads i_len words starting at i_base_addr from a fixed-latency RAM and returns them as a
// valid/ready stream. Reads are only issued when a FIFO slot is already reserved for the
// returning word, so backpressure never drops data.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for i_start
// S_RUN   | issuing read addresses as credit allows
// S_DRAIN | all addresses issued, waiting for the last word to be taken
// S_DONE  | one-cycle completion, o_done high
module ram_read_streamer #(
  parameter int DATA_R     = 8,
  parameter int DEPTH_R    = 8,
  parameter int DELAY      = 0,
  parameter int FIFO_DEPTH = 4
) (
  input logic                 clk,
  input logic                 rst,
  ram_read_streamer_if.slave  bus
);

  localparam int PW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNTW = $clog2(FIFO_DEPTH + 1);
  localparam int IFW  = $clog2(DELAY + 2);
  localparam int SUMW = $clog2(FIFO_DEPTH + DELAY + 2);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t state_q, state_d;

  logic [DEPTH_R-1:0]   addr_q;
  logic [DEPTH_R:0]     remain_q;
  logic [DELAY:0]       pipe_v_q;
  logic [DELAY:0]       pipe_last_q;
  logic [IFW-1:0]       inflight_q;
  logic [DATA_R-1:0]    fifo_data_q [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fifo_last_q;
  logic [PW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [CNTW-1:0]      count_q;

  logic            accept, issue, last_issue, push, pop, credit_ok, fifo_valid;
  logic [SUMW-1:0] occupancy;

  // Credits: every issued read owns a FIFO slot until it is popped; a pop frees it next cycle.
  assign occupancy  = SUMW'(inflight_q) + SUMW'(count_q);
  assign credit_ok  = occupancy < SUMW'(FIFO_DEPTH);
  assign fifo_valid = (count_q != '0);
  assign push       = pipe_v_q[DELAY];
  assign pop        = fifo_valid && bus.i_ready;
  assign last_issue = issue && (remain_q == (DEPTH_R+1)'(1));

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state, issue decision and status outputs.
  always_comb begin
    state_d     = state_q;
    accept      = 1'b0;
    issue       = 1'b0;
    bus.o_busy  = (state_q != S_IDLE);
    bus.o_done  = (state_q == S_DONE);
    case (state_q)
      S_IDLE: begin
        if (bus.i_start) begin
          accept  = 1'b1;
          state_d = (bus.i_len == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (credit_ok) begin
          issue = 1'b1;
          if (remain_q == (DEPTH_R+1)'(1)) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (pop && fifo_last_q[rd_ptr_q]) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Read address and words-left down-counter; the address wraps naturally at 2^DEPTH_R.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q   <= '0;
      remain_q <= '0;
    end else if (accept) begin
      addr_q   <= bus.i_base_addr;
      remain_q <= bus.i_len;
    end else if (issue) begin
      addr_q   <= addr_q + DEPTH_R'(1);
      remain_q <= remain_q - (DEPTH_R+1)'(1);
    end
  end

  // Issue tokens travel alongside the RAM latency so each returning word is pushed exactly once.
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_v_q    <= '0;
      pipe_last_q <= '0;
      inflight_q  <= '0;
    end else begin
      pipe_v_q[0]    <= issue;
      pipe_last_q[0] <= last_issue;
      for (int k = 1; k <= DELAY; k++) begin
        pipe_v_q[k]    <= pipe_v_q[k-1];
        pipe_last_q[k] <= pipe_last_q[k-1];
      end
      inflight_q <= inflight_q + IFW'(issue) - IFW'(push);
    end
  end

  // Skid FIFO; push and pop may coincide at any occupancy since credit prevents overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      fifo_last_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_data_q[i] <= '0;
    end else begin
      if (push) begin
        fifo_data_q[wr_ptr_q] <= bus.i_rdata;
        fifo_last_q[wr_ptr_q] <= pipe_last_q[DELAY];
        wr_ptr_q              <= ptr_next(wr_ptr_q);
      end
      if (pop) rd_ptr_q <= ptr_next(rd_ptr_q);
      count_q <= count_q + CNTW'(push) - CNTW'(pop);
    end
  end

  assign bus.o_raddr = addr_q;
  assign bus.o_valid = fifo_valid;
  assign bus.o_data  = fifo_data_q[rd_ptr_q];
  assign bus.o_last  = fifo_valid && fifo_last_q[rd_ptr_q];

endmodule
